// File: rtl/sr_pkg.sv
// Shared types and default constants for the SR latch driver.
//
// Contents:
//   sr_state_e    FSM state encoding {IDLE, DEAD, PULSE, CHECK}
//   *_DEF         default pulse width, dead time, timeout and counter width
//   SYNC_LAT      depth of the q_fb synchronizer. CHECK ignores q_sync for
//                 this many cycles so that the value it compares reflects the
//                 latch after S/R have been released.
package sr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DEAD  = 2'd1,
      PULSE = 2'd2,
      CHECK = 2'd3
   } sr_state_e;

   localparam int PULSE_W_DEF = 4;
   localparam int DEAD_W_DEF  = 2;
   localparam int TIMEOUT_DEF = 16;
   localparam int CNT_W_DEF   = 8;
   localparam int SYNC_LAT    = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared by reset.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset; clears both stages
//   d     asynchronous input
//   q     synchronized output, two clk cycles behind d
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Drives the S/R inputs of an external NOR SR latch with non-overlapping,
// fixed-width pulses preceded by dead time, then confirms the latch value
// through a synchronized Q readback.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   req_valid  request present
//   req_set    1 = set latch, 0 = clear latch
//   req_ready  controller idle and able to accept a request
//   S, R       latch set / reset drive (registered, never both high)
//   q_fb       latch Q, asynchronous to clk
//   done       one-cycle pulse: request completed and Q verified
//   err        one-cycle pulse: Q did not reach the target in TIMEOUT cycles
//   q_state    last verified latch value
//
// Build option:
//   SR_SKIP_REDUNDANT_EN  when defined, a request whose target already matches
//                         q_sync completes with done on the next cycle and
//                         no S/R pulse.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// DEAD  | S=R=0 for DEAD_W cycles ahead of the pulse
// PULSE | S=tgt, R=~tgt for PULSE_W cycles
// CHECK | S=R=0, waiting up to TIMEOUT cycles for q_sync==tgt
module sr_latch_driver
   import sr_pkg::*;
#(
   parameter int PULSE_W = PULSE_W_DEF,
   parameter int DEAD_W  = DEAD_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid,
   input  logic req_set,
   output logic req_ready,
   output logic S,
   output logic R,
   input  logic q_fb,
   output logic done,
   output logic err,
   output logic q_state
);

   localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_W - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE     = CNT_W'(SYNC_LAT);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   sr_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tgt_q, tgt_d;
   logic             s_q, s_d;
   logic             r_q, r_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             q_state_q, q_state_d;
   logic             req_ready_q, req_ready_d;
   logic             q_sync;
   logic             accept;
   logic             check_open;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (q_fb),
      .q   (q_sync)
   );

   assign accept = req_valid && req_ready_q && (state_q == IDLE);

   // The first SYNC_LAT samples in CHECK may still carry pre-release values;
   // the final timeout cycle is always open so tiny TIMEOUT values still work.
   assign check_open = (cnt_q >= SETTLE) || (cnt_q == TO_LAST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      tgt_d     = tgt_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      q_state_d = q_state_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               tgt_d = req_set;
`ifdef SR_SKIP_REDUNDANT_EN
               if (q_sync == req_set) begin
                  done_d    = 1'b1;
                  q_state_d = req_set;
               end else begin
                  state_d = DEAD;
               end
`else
               state_d = DEAD;
`endif
            end
         end
         DEAD: begin
            if (cnt_q == DEAD_LAST) begin
               state_d = PULSE;
               cnt_d   = '0;
            end
         end
         PULSE: begin
            if (cnt_q == PULSE_LAST) begin
               state_d = CHECK;
               cnt_d   = '0;
            end
         end
         CHECK: begin
            if (check_open && (q_sync == tgt_q)) begin
               done_d    = 1'b1;
               q_state_d = tgt_q;
               state_d   = IDLE;
            end else if (cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it.
      s_d         = (state_d == PULSE) &&  tgt_d;
      r_d         = (state_d == PULSE) && !tgt_d;
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         tgt_q       <= 1'b0;
         s_q         <= 1'b0;
         r_q         <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         q_state_q   <= 1'b0;
         req_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tgt_q       <= tgt_d;
         s_q         <= s_d;
         r_q         <= r_d;
         done_q      <= done_d;
         err_q       <= err_d;
         q_state_q   <= q_state_d;
         req_ready_q <= req_ready_d;
      end
   end

   assign S         = s_q;
   assign R         = r_q;
   assign done      = done_q;
   assign err       = err_q;
   assign q_state   = q_state_q;
   assign req_ready = req_ready_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver with a behavioural latch model.
module tb_sr_latch_driver;

   localparam int PW = 4;
   localparam int DW = 2;
   localparam int TO = 16;
   localparam int CW = 8;
   localparam int SYNC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req_valid = 1'b0;
   logic req_set = 1'b0;
   logic req_ready, S, R, done, err, q_state;
   logic q_fb;

   int vectors = 0;
   int miscompares = 0;

   // Latch environment: stuck_en forces Q, otherwise S sets and R clears.
   logic stuck_en = 1'b1;
   logic stuck_val = 1'b0;
   logic lat_val = 1'b0;      // model of the latch value
   logic exp_qstate = 1'b0;   // model of the last verified value

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (stuck_en)  q_fb <= stuck_val;
      else if (S)    q_fb <= 1'b1;
      else if (R)    q_fb <= 1'b0;
   end

   sr_latch_driver #(.PULSE_W(PW), .DEAD_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_set   (req_set),
      .req_ready (req_ready),
      .S         (S),
      .R         (R),
      .q_fb      (q_fb),
      .done      (done),
      .err       (err),
      .q_state   (q_state)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One request. Expected timeline is computed from the cycle counts
   // measured from the accepting edge (cycle 1 = first cycle after it).
   task automatic run_txn(input logic tgt, input bit hold_valid);
      int  guard;
      int  k_end;
      bit  skip;
      bit  ok;
      logic exp_s, exp_r;
      req_valid = 1'b1;
      req_set   = tgt;
      guard = 0;
      while (!req_ready && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      check("accept_wait", req_ready, 1'b1);
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      skip = 1'b0;
`ifdef SR_SKIP_REDUNDANT_EN
      skip = (lat_val == tgt);
`endif
      ok = stuck_en ? (stuck_val == tgt) : 1'b1;
      if (skip)    k_end = 1;
      else if (ok) k_end = 1 + DW + PW + SYNC + 1;
      else         k_end = 1 + DW + PW + TO;
      @(posedge clk);
      #1;
      if (!hold_valid) req_valid = 1'b0;
      for (int k = 1; k <= k_end; k++) begin
         @(negedge clk);
         exp_s = !skip && (k >= 1 + DW) && (k <= DW + PW) &&  tgt;
         exp_r = !skip && (k >= 1 + DW) && (k <= DW + PW) && !tgt;
         check($sformatf("S_k%0d", k), S, exp_s);
         check($sformatf("R_k%0d", k), R, exp_r);
         check($sformatf("no_overlap_k%0d", k), S && R, 1'b0);
         check($sformatf("done_k%0d", k), done, (k == k_end) && ok);
         check($sformatf("err_k%0d", k), err, (k == k_end) && !ok);
         check($sformatf("ready_k%0d", k), req_ready, k == k_end);
      end
      if (!skip && !stuck_en) lat_val = tgt;
      if (ok) exp_qstate = tgt;
      check("q_state", q_state, exp_qstate);
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic t;
      // reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_S", S, 1'b0);
      check("rst_R", R, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_q_state", q_state, 1'b0);
      check("rst_ready", req_ready, 1'b0);
      rst = 1'b0;
      stuck_en = 1'b0;
      @(negedge clk);
      check("idle_ready", req_ready, 1'b1);

      // set, clear, set, then stuck-at-0 with a set request
      run_txn(1'b1, 1'b0);
      idle(2);
      run_txn(1'b0, 1'b0);
      idle(2);
      run_txn(1'b1, 1'b0);
      idle(2);
      stuck_en = 1'b1; stuck_val = 1'b0; lat_val = 1'b0;
      idle(4);
      run_txn(1'b1, 1'b0);
      stuck_en = 1'b0;
      idle(3);

      // back-to-back with req_valid held and alternating targets
      t = ~lat_val;
      for (int i = 0; i < 6; i++) begin
         run_txn(t, i != 5);
         t = ~t;
      end
      idle(3);

      // random requests with an occasionally stuck latch
      for (int i = 0; i < 10; i++) begin
         stuck_en = ($urandom_range(0, 3) == 0);
         stuck_val = 1'($urandom_range(0, 1));
         if (stuck_en) lat_val = stuck_val;
         idle(4);
         run_txn(1'($urandom_range(0, 1)), 1'b0);
         stuck_en = 1'b0;
      end
      idle(3);

      // redundant request (skipped when the option is built in)
      run_txn(lat_val, 1'b0);
      idle(3);

      // reset during the second pulse cycle
      t = ~lat_val;
      req_valid = 1'b1;
      req_set = t;
      for (int g = 0; g < 60 && !req_ready; g++) @(negedge clk);
      check("mid_accept_wait", req_ready, 1'b1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (1 + DW + 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_S", S, 1'b0);
      check("mid_R", R, 1'b0);
      check("mid_done", done, 1'b0);
      check("mid_err", err, 1'b0);
      check("mid_ready", req_ready, 1'b0);
      rst = 1'b0;
      lat_val = t;
      exp_qstate = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("post_rst_ready_%0d", k), req_ready, 1'b1);
         check($sformatf("post_rst_done_%0d", k), done, 1'b0);
         check($sformatf("post_rst_err_%0d", k), err, 1'b0);
         check($sformatf("post_rst_S_%0d", k), S, 1'b0);
      end
      check("post_rst_q_state", q_state, 1'b0);
      run_txn(~lat_val, 1'b0);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
